cpu_exec_ctrl: RTL and testbench

Execution controller for the single-cycle MIPS datapath. It replaces direct push-button clocking of the PC and register file with a clock-enable generated on the board clock. It supports three modes: single-step from a debounced key, free-run at a divided rate, and halt on a PC breakpoint. It sits between the DE2 keys/switches and the CPU's PC, register file and data memory enables.

---
 rtl/cpu_exec_pkg.sv | 21 ++
 rtl/cpu_exec_ctrl_if.sv | 28 ++
 rtl/cpu_exec_ctrl_debounce.sv | 45 ++++
 rtl/cpu_exec_ctrl.sv | 121 ++++++++++++
 tb/tb_cpu_exec_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_exec_pkg.sv
// Shared types and defaults for the MIPS execution controller.
package cpu_exec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_STEP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BREAK = 2'b11
    } exec_state_e;

    localparam int unsigned DEB_CYCLES_DEF = 500000;
    localparam int unsigned RUN_DIV_DEF    = 5000000;
    localparam int unsigned PC_W_DEF       = 8;
    localparam int unsigned CNT_W_DEF      = 16;

    // Bits needed to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_exec_ctrl_if.sv
// Key/switch/PC inputs and enable/status outputs of the execution controller.
interface cpu_exec_ctrl_if
    import cpu_exec_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             key_step;
    logic             sw_run;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  brk_addr;
    logic             cpu_en;
    exec_state_e      state;
    logic [CNT_W-1:0] instr_cnt;
    logic             brk_hit;

    modport master (
        output key_step, sw_run, pc, brk_addr,
        input  cpu_en, state, instr_cnt, brk_hit
    );

    modport slave (
        input  key_step, sw_run, pc, brk_addr,
        output cpu_en, state, instr_cnt, brk_hit
    );

endinterface

// File: rtl/cpu_exec_ctrl_debounce.sv
// Step-key debouncer: 2-FF synchronizer, stability counter, press pulse.
module key_debounce
    import cpu_exec_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic step_pulse
);

    localparam int unsigned   CW   = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Level follows the synchronized key only after DEB_CYCLES disagreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            level      <= 1'b1;
            cnt        <= '0;
            step_pulse <= 1'b0;
        end else begin
            sync1      <= key;
            sync2      <= sync1;
            step_pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt        <= '0;
                level      <= sync2;
                step_pulse <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Execution controller: single-step / free-run / breakpoint CPU clock-enable.
// Optional breakpoint logic enabled by defining CPU_EXEC_CTRL_BRK_EN.
module cpu_exec_ctrl
    import cpu_exec_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned RUN_DIV    = RUN_DIV_DEF,
    parameter int unsigned PC_W       = PC_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    cpu_exec_ctrl_if.slave  bus
);

    localparam int unsigned    DIV_W    = cnt_width(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    exec_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cpu_en_q, cpu_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_pulse;
    logic             tick_c;
    logic             brk_match_c;
    logic [PC_W-1:0]  pc_c;
    logic [PC_W-1:0]  brk_c;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (bus.key_step),
        .step_pulse (step_pulse)
    );

    assign pc_c   = bus.pc;
    assign brk_c  = bus.brk_addr;
    assign tick_c = (div_q == DIV_LAST);

`ifdef CPU_EXEC_CTRL_BRK_EN
    logic brk_hit_q, brk_hit_d;
    assign brk_match_c = (pc_c == brk_c);
    assign bus.brk_hit = brk_hit_q;
`else
    logic unused_brk;
    assign unused_brk  = ^{pc_c, brk_c};
    assign brk_match_c = 1'b0;
    assign bus.brk_hit = 1'b0;
`endif

    // Next-state, divider and enable decode; the enable is raised on entry to STEP
    // or on a non-breaking divider tick so it is registered alongside the state.
    always_comb begin
        state_d  = state_q;
        div_d    = '0;
        cpu_en_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.sw_run) begin
                    state_d = ST_RUN;
                end else if (step_pulse) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
                end
            end
            ST_STEP: state_d = ST_IDLE;
            ST_RUN: begin
                if (!bus.sw_run) begin
                    state_d = ST_IDLE;
                end else if (tick_c) begin
                    if (brk_match_c) state_d = ST_BREAK;
                    else             cpu_en_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_BREAK: begin
`ifdef CPU_EXEC_CTRL_BRK_EN
                if (!bus.sw_run) begin
                    state_d = ST_IDLE;
                end else if (step_pulse) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        cnt_d = cnt_q + CNT_W'(cpu_en_d);
`ifdef CPU_EXEC_CTRL_BRK_EN
        brk_hit_d = (state_d == ST_BREAK);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            cpu_en_q <= 1'b0;
            cnt_q    <= '0;
`ifdef CPU_EXEC_CTRL_BRK_EN
            brk_hit_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cpu_en_q <= cpu_en_d;
            cnt_q    <= cnt_d;
`ifdef CPU_EXEC_CTRL_BRK_EN
            brk_hit_q <= brk_hit_d;
`endif
        end
    end

    assign bus.cpu_en    = cpu_en_q;
    assign bus.state     = state_q;
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed self-checking bench for cpu_exec_ctrl (DEB_CYCLES=4, RUN_DIV=3, plus a RUN_DIV=1 wrap instance).
module tb_cpu_exec_ctrl;
    import cpu_exec_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned DIV = 3;

    typedef struct {
        logic       key;
        logic       sw;
        logic [1:0] st;
        logic       en;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_exec_ctrl_if #(.PC_W(8), .CNT_W(16)) bus ();
    cpu_exec_ctrl_if #(.PC_W(8), .CNT_W(4))  bus2 ();

    cpu_exec_ctrl #(.DEB_CYCLES(DEB), .RUN_DIV(DIV), .PC_W(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cpu_exec_ctrl #(.DEB_CYCLES(DEB), .RUN_DIV(1), .PC_W(8), .CNT_W(4)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    vec_t vecs [27];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  pulses;
        int  first;
        int  hits;
        int  ones;
        bit  found;

        vecs = '{
            '{1'b0, 1'b0, 2'd0, 1'b0}, '{1'b0, 1'b0, 2'd0, 1'b0}, '{1'b0, 1'b0, 2'd0, 1'b0},
            '{1'b0, 1'b0, 2'd0, 1'b0}, '{1'b0, 1'b0, 2'd0, 1'b0}, '{1'b0, 1'b0, 2'd0, 1'b0},
            '{1'b0, 1'b1, 2'd2, 1'b0}, '{1'b0, 1'b1, 2'd2, 1'b0}, '{1'b1, 1'b1, 2'd2, 1'b0},
            '{1'b1, 1'b1, 2'd2, 1'b1}, '{1'b1, 1'b1, 2'd2, 1'b0}, '{1'b1, 1'b1, 2'd2, 1'b0},
            '{1'b1, 1'b1, 2'd2, 1'b1}, '{1'b1, 1'b1, 2'd2, 1'b0}, '{1'b0, 1'b1, 2'd2, 1'b0},
            '{1'b0, 1'b1, 2'd2, 1'b1}, '{1'b0, 1'b1, 2'd2, 1'b0}, '{1'b0, 1'b1, 2'd2, 1'b0},
            '{1'b0, 1'b1, 2'd2, 1'b1}, '{1'b0, 1'b1, 2'd2, 1'b0}, '{1'b0, 1'b1, 2'd2, 1'b0},
            '{1'b0, 1'b1, 2'd2, 1'b1}, '{1'b0, 1'b1, 2'd2, 1'b0}, '{1'b0, 1'b1, 2'd2, 1'b0},
            '{1'b0, 1'b1, 2'd2, 1'b1}, '{1'b0, 1'b1, 2'd2, 1'b0}, '{1'b0, 1'b1, 2'd2, 1'b0}
        };

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.key_step  = 1'($urandom);
            bus.sw_run    = 1'($urandom);
            bus.pc        = 8'($urandom);
            bus.brk_addr  = 8'($urandom);
            bus2.key_step = 1'($urandom);
            bus2.sw_run   = 1'($urandom);
            bus2.pc       = 8'($urandom);
            bus2.brk_addr = 8'($urandom);
            step();
        end
        chk("reset_state", bus.state, ST_IDLE);
        chk("reset_en", bus.cpu_en, 0);
        chk("reset_cnt", bus.instr_cnt, 0);
        chk("reset_brk", bus.brk_hit, 0);

        rst_n = 1'b1;
        bus.key_step = 1'b1;  bus.sw_run = 1'b0;  bus.pc = 8'h00;  bus.brk_addr = 8'hFF;
        bus2.key_step = 1'b1; bus2.sw_run = 1'b0; bus2.pc = 8'h00; bus2.brk_addr = 8'hFF;
        for (int i = 0; i < 3; i++) step();

        // Debounce: bouncing key, then hold
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            bus.key_step = ((i / 2) % 2 == 1);
            step();
            if (bus.cpu_en) pulses++;
        end
        chk("bounce_no_pulse", pulses, 0);
        bus.key_step = 1'b0;
        pulses = 0;
        first = -1;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (bus.cpu_en) begin
                pulses++;
                if (first < 0) first = c;
                chk("step_state", bus.state, ST_STEP);
            end
        end
        chk("deb_pulses", pulses, 1);
        chk("deb_latency", first, 7);
        exp_cnt = 1;
        chk("deb_cnt", bus.instr_cnt, exp_cnt);
        bus.key_step = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.cpu_en) pulses++;
        end
        chk("release_no_pulse", pulses, 0);

        // Free run, pulses every DIV cycles
        bus.pc = 8'h00;
        bus.sw_run = 1'b1;
        step();
        chk("run_enter", bus.state, ST_RUN);
        for (int i = 1; i <= 30; i++) begin
            step();
            chk("run_en", bus.cpu_en, (i % DIV == 0));
            if (bus.cpu_en) bus.pc = bus.pc + 8'd1;
        end
        exp_cnt += 10;
        chk("run_cnt", bus.instr_cnt, exp_cnt);
        bus.sw_run = 1'b0;
        step();
        chk("run_stop_state", bus.state, ST_IDLE);
        chk("run_stop_en", bus.cpu_en, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.cpu_en) pulses++;
        end
        chk("idle_no_pulse", pulses, 0);

`ifdef CPU_EXEC_CTRL_BRK_EN
        // Breakpoint halt and step-over
        bus.pc = 8'h00;
        bus.brk_addr = 8'h05;
        bus.sw_run = 1'b1;
        pulses = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (bus.cpu_en) begin
                pulses++;
                bus.pc = bus.pc + 8'd1;
            end
            if (bus.state == ST_BREAK) found = 1'b1;
        end
        chk("brk_reached", found, 1);
        chk("brk_pulses", pulses, 5);
        chk("brk_pc", bus.pc, 8'h05);
        chk("brk_hit", bus.brk_hit, 1);
        chk("brk_en", bus.cpu_en, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.cpu_en) pulses++;
        end
        chk("brk_hold_pulses", pulses, 0);
        chk("brk_hold_state", bus.state, ST_BREAK);
        bus.key_step = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.cpu_en) found = 1'b1;
        end
        chk("brk_step_pulse", found, 1);
        chk("brk_step_state", bus.state, ST_STEP);
        bus.pc = bus.pc + 8'd1;
        step();
        chk("brk_after_idle", bus.state, ST_IDLE);
        chk("brk_after_en", bus.cpu_en, 0);
        step();
        chk("brk_resume", bus.state, ST_RUN);
        chk("brk_resume_hit", bus.brk_hit, 0);
        chk("brk_resume_pc", bus.pc, 8'h06);
        exp_cnt += 6;
        bus.sw_run = 1'b0;
        bus.key_step = 1'b1;
        step();
`else
        // Breakpoint disabled: run passes the breakpoint address
        bus.pc = 8'h00;
        bus.brk_addr = 8'h02;
        bus.sw_run = 1'b1;
        pulses = 0;
        hits = 0;
        for (int i = 0; i < 19; i++) begin
            step();
            if (bus.brk_hit || bus.state == ST_BREAK) hits++;
            if (bus.cpu_en) begin
                pulses++;
                bus.pc = bus.pc + 8'd1;
            end
        end
        chk("nobrk_pulses", pulses, 6);
        chk("nobrk_hits", hits, 0);
        chk("nobrk_pc", bus.pc, 8'h06);
        exp_cnt += 6;
        bus.sw_run = 1'b0;
        step();
`endif
        bus.brk_addr = 8'hFF;
        for (int i = 0; i < 12; i++) step();
        chk("mid_cnt", bus.instr_cnt, exp_cnt);

        // Step press coinciding with run switch, then press during RUN
        for (int i = 0; i < 27; i++) begin
            bus.key_step = vecs[i].key;
            bus.sw_run   = vecs[i].sw;
            step();
            chk($sformatf("vec%0d_state", i), bus.state, vecs[i].st);
            chk($sformatf("vec%0d_en", i), bus.cpu_en, vecs[i].en);
            if (vecs[i].en) exp_cnt++;
        end
        chk("vec_cnt", bus.instr_cnt, exp_cnt);
        bus.sw_run = 1'b0;
        bus.key_step = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.cpu_en) pulses++;
        end
        chk("vec_drain", pulses, 0);

        // RUN_DIV=1 instance: enable every cycle, 4-bit counter wraps
        bus2.sw_run = 1'b1;
        step();
        chk("div1_enter", bus2.state, ST_RUN);
        chk("div1_first_en", bus2.cpu_en, 0);
        ones = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus2.cpu_en) ones++;
        end
        chk("div1_ones", ones, 15);
        chk("div1_cnt15", bus2.instr_cnt, 15);
        step();
        chk("wrap_cnt0", bus2.instr_cnt, 0);
        chk("wrap_en", bus2.cpu_en, 1);
        step();
        chk("wrap_cnt1", bus2.instr_cnt, 1);

        // Reset while running
        rst_n = 1'b0;
        step();
        chk("rst_run_en", bus2.cpu_en, 0);
        chk("rst_run_state", bus2.state, ST_IDLE);
        chk("rst_run_cnt", bus2.instr_cnt, 0);
        chk("rst_dut_cnt", bus.instr_cnt, 0);
        rst_n = 1'b1;
        bus2.sw_run = 1'b0;
        step();
        chk("rst_run_idle", bus2.cpu_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
